// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the two-master AXI read arbiter.
package axi_rd_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 64;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AR/R signal bundle between two read masters, the arbiter and the memory port.
interface axi_rd_arbiter_if #(
   parameter int ADDR_W = axi_rd_arbiter_pkg::ADDR_W_DEF,
   parameter int DATA_W = axi_rd_arbiter_pkg::DATA_W_DEF
) ();

   logic [ADDR_W-1:0] m0_araddr;
   logic              m0_arvalid;
   logic              m0_arready;
   logic              m0_rvalid;
   logic              m0_rready;
   logic [DATA_W-1:0] m0_rdata;
   logic [1:0]        m0_rresp;

   logic [ADDR_W-1:0] m1_araddr;
   logic              m1_arvalid;
   logic              m1_arready;
   logic              m1_rvalid;
   logic              m1_rready;
   logic [DATA_W-1:0] m1_rdata;
   logic [1:0]        m1_rresp;

   logic [ADDR_W-1:0] s_araddr;
   logic              s_arvalid;
   logic              s_arready;
   logic              s_rvalid;
   logic              s_rready;
   logic [DATA_W-1:0] s_rdata;
   logic [1:0]        s_rresp;

   // Environment view: the two masters plus the memory port.
   modport master (
      output m0_araddr, m0_arvalid, m0_rready,
      input  m0_arready, m0_rvalid, m0_rdata, m0_rresp,
      output m1_araddr, m1_arvalid, m1_rready,
      input  m1_arready, m1_rvalid, m1_rdata, m1_rresp,
      input  s_araddr, s_arvalid, s_rready,
      output s_arready, s_rvalid, s_rdata, s_rresp
   );

   modport slave (
      input  m0_araddr, m0_arvalid, m0_rready,
      output m0_arready, m0_rvalid, m0_rdata, m0_rresp,
      input  m1_araddr, m1_arvalid, m1_rready,
      output m1_arready, m1_rvalid, m1_rdata, m1_rresp,
      output s_araddr, s_arvalid, s_rready,
      input  s_arready, s_rvalid, s_rdata, s_rresp
   );

endinterface

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker.
module axi_rd_arbiter_rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic [1:0] o_gnt,
   output logic       o_gnt_idx
);

   always_comb begin
      o_gnt_idx = 1'b0;
      o_gnt     = 2'b00;
      unique case (i_req)
         2'b11:   o_gnt_idx = ~i_last;
         2'b10:   o_gnt_idx = 1'b1;
         default: o_gnt_idx = 1'b0;
      endcase
      if (|i_req) begin
         o_gnt = o_gnt_idx ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read arbiter, one outstanding read, registered slave AR.
module axi_rd_arbiter
   import axi_rd_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic           clock,
   input  logic           reset,
   axi_rd_arbiter_if.slave bus
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_grant;
   logic              w_grant_nxt;
   logic              r_last;
   logic              w_last_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_addr_nxt;

   logic [1:0]        w_req;
   logic [1:0]        w_gnt;
   logic              w_gnt_idx;
   logic              w_s_rready;

   assign w_req = {bus.m1_arvalid, bus.m0_arvalid};

   axi_rd_arbiter_rr_arb2 u_rr (
      .i_req     (w_req),
      .i_last    (r_last),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= IDLE;
         r_grant <= 1'b0;
         r_last  <= 1'b1;
         r_addr  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_last  <= w_last_nxt;
         r_addr  <= w_addr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_last_nxt  = r_last;
      w_addr_nxt  = r_addr;
      unique case (r_state)
         IDLE: begin
            if (|w_req) begin
               w_state_nxt = ADDR;
               w_grant_nxt = w_gnt_idx;
               w_addr_nxt  = w_gnt_idx ? bus.m1_araddr : bus.m0_araddr;
            end
         end
         ADDR: begin
            if (bus.s_arready) begin
               w_state_nxt = DATA;
            end
         end
         DATA: begin
            if (bus.s_rvalid && w_s_rready) begin
               w_state_nxt = IDLE;
               w_last_nxt  = r_grant;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs are forced quiet while reset is held, even before the first edge.
   always_comb begin
      bus.m0_arready = 1'b0;
      bus.m1_arready = 1'b0;
      bus.m0_rvalid  = 1'b0;
      bus.m1_rvalid  = 1'b0;
      bus.m0_rdata   = {DATA_W{1'b0}};
      bus.m1_rdata   = {DATA_W{1'b0}};
      bus.m0_rresp   = 2'b00;
      bus.m1_rresp   = 2'b00;
      bus.s_araddr   = r_addr;
      bus.s_arvalid  = 1'b0;
      w_s_rready     = 1'b0;
      if (reset) begin
         unique case (r_state)
            IDLE: begin
               bus.m0_arready = w_gnt[0];
               bus.m1_arready = w_gnt[1];
            end
            ADDR: bus.s_arvalid = 1'b1;
            DATA: begin
               if (r_grant) begin
                  w_s_rready    = bus.m1_rready;
                  bus.m1_rvalid = bus.s_rvalid;
                  bus.m1_rdata  = bus.s_rdata;
                  bus.m1_rresp  = bus.s_rresp;
               end else begin
                  w_s_rready    = bus.m0_rready;
                  bus.m0_rvalid = bus.s_rvalid;
                  bus.m0_rdata  = bus.s_rdata;
                  bus.m0_rresp  = bus.s_rresp;
               end
            end
            default: w_s_rready = 1'b0;
         endcase
      end
      bus.s_rready = w_s_rready;
   end

endmodule
